// File: rtl/ts_sync_lock_detector_if.sv
// Byte-stream bundle between the upstream FIFO/mux stage and the TS lock detector,
// including the detector's aligned output stream and its QoS counters.
interface ts_sync_lock_detector_if #(
   parameter int unsigned CNT_W = 16
);
   logic [9:0]       data_in;
   logic [7:0]       data_out;
   logic             valid_out;
   logic             pkt_start;
   logic             lock;
   logic [CNT_W-1:0] pkt_cnt;
   logic [CNT_W-1:0] sync_err_cnt;
   logic [CNT_W-1:0] lock_loss_cnt;

   modport master (
      output data_in,
      input  data_out, valid_out, pkt_start, lock,
      input  pkt_cnt, sync_err_cnt, lock_loss_cnt
   );

   modport slave (
      input  data_in,
      output data_out, valid_out, pkt_start, lock,
      output pkt_cnt, sync_err_cnt, lock_loss_cnt
   );
endinterface

// File: rtl/ts_sync_lock_detector.sv
// MPEG-2 TS packet alignment: acquires lock on SYNC_BYTE at PKT_LEN spacing, flywheels
// through corrupted sync bytes, emits aligned bytes with a packet-start strobe and QoS counters.
module ts_sync_lock_detector #(
   parameter int unsigned PKT_LEN    = 188,
   parameter logic [7:0]  SYNC_BYTE  = 8'h47,
   parameter int unsigned LOCK_CNT   = 3,
   parameter int unsigned UNLOCK_CNT = 3,
   parameter int unsigned CNT_W      = 16
) (
   input  logic                    clk,
   input  logic                    rst,
   ts_sync_lock_detector_if.slave  bus
);
   localparam int unsigned POS_W  = $clog2(PKT_LEN);
   localparam int unsigned HIT_W  = $clog2(LOCK_CNT + 1);
   localparam int unsigned MISS_W = $clog2(UNLOCK_CNT + 1);

   typedef enum logic [1:0] {SEARCH, VERIFY, LOCKED} state_t;

   state_t            state;
   logic [POS_W-1:0]  pos;
   logic [POS_W-1:0]  pos_next;
   logic [HIT_W-1:0]  hit;
   logic [MISS_W-1:0] miss;
   logic [7:0]        data_q;
   logic              valid_q;
   logic              start_q;
   logic              lock_q;
   logic [CNT_W-1:0]  pkt_cnt_q;
   logic [CNT_W-1:0]  sync_err_q;
   logic [CNT_W-1:0]  lock_loss_q;

   logic in_valid;
   logic is_sync;
   logic at_start;
   logic unused_sync_flag;

   // The upstream sync flag is advisory only; the byte compare decides.
   assign unused_sync_flag = bus.data_in[8];
   assign in_valid = bus.data_in[9];
   assign is_sync  = (bus.data_in[7:0] == SYNC_BYTE);
   assign at_start = (pos == '0);
   assign pos_next = (pos == POS_W'(PKT_LEN - 1)) ? '0 : pos + POS_W'(1);

   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (&v) ? v : v + CNT_W'(1);
   endfunction

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= SEARCH;
         pos         <= '0;
         hit         <= '0;
         miss        <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         start_q     <= 1'b0;
         lock_q      <= 1'b0;
         pkt_cnt_q   <= '0;
         sync_err_q  <= '0;
         lock_loss_q <= '0;
      end else begin
         valid_q <= 1'b0;
         start_q <= 1'b0;
         if (in_valid) begin
            data_q <= bus.data_in[7:0];
            pos    <= pos_next;
            case (state)
               SEARCH: begin
                  if (is_sync) begin
                     state <= VERIFY;
                     hit   <= HIT_W'(1);
                     pos   <= POS_W'(1);
                  end else begin
                     pos <= '0;
                  end
               end
               VERIFY: begin
                  if (at_start) begin
                     if (!is_sync) begin
                        state <= SEARCH;
                        pos   <= '0;
                     end else if (hit == HIT_W'(LOCK_CNT - 1)) begin
                        state     <= LOCKED;
                        lock_q    <= 1'b1;
                        miss      <= '0;
                        pkt_cnt_q <= sat_inc(pkt_cnt_q);
                        valid_q   <= 1'b1;
                        start_q   <= 1'b1;
                     end else begin
                        hit <= hit + HIT_W'(1);
                     end
                  end
               end
               LOCKED: begin
                  valid_q <= 1'b1;
                  start_q <= at_start;
                  if (at_start) begin
                     if (is_sync) begin
                        miss      <= '0;
                        pkt_cnt_q <= sat_inc(pkt_cnt_q);
                     end else begin
                        sync_err_q <= sat_inc(sync_err_q);
                        // Final miss: the byte is suppressed and lock drops on the same edge.
                        if (miss == MISS_W'(UNLOCK_CNT - 1)) begin
                           state       <= SEARCH;
                           lock_q      <= 1'b0;
                           miss        <= '0;
                           pos         <= '0;
                           lock_loss_q <= sat_inc(lock_loss_q);
                           valid_q     <= 1'b0;
                           start_q     <= 1'b0;
                        end else begin
                           miss <= miss + MISS_W'(1);
                        end
                     end
                  end
               end
               default: begin
                  state <= SEARCH;
                  pos   <= '0;
               end
            endcase
         end
      end
   end

   assign bus.data_out      = data_q;
   assign bus.valid_out     = valid_q;
   assign bus.pkt_start     = start_q;
   assign bus.lock          = lock_q;
   assign bus.pkt_cnt       = pkt_cnt_q;
   assign bus.sync_err_cnt  = sync_err_q;
   assign bus.lock_loss_cnt = lock_loss_q;
endmodule

// File: tb/tb_ts_sync_lock_detector.sv
// Randomized bench for ts_sync_lock_detector: two instances (16-bit and 4-bit counters)
// share one byte stream and are compared every cycle against a packet-anchor reference model.
module tb_ts_sync_lock_detector;
   localparam int unsigned PKT_LEN    = 188;
   localparam logic [7:0]  SYNC       = 8'h47;
   localparam int          LOCK_CNT   = 3;
   localparam int          UNLOCK_CNT = 3;
   localparam int          M_SEARCH = 0, M_VERIFY = 1, M_LOCKED = 2;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [9:0] din = '0;

   always #5 clk = ~clk;

   ts_sync_lock_detector_if #(.CNT_W(16)) bus16 ();
   ts_sync_lock_detector_if #(.CNT_W(4))  bus4 ();
   assign bus16.data_in = din;
   assign bus4.data_in  = din;

   ts_sync_lock_detector #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(SYNC), .LOCK_CNT(LOCK_CNT),
                           .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(16))
      dut16 (.clk(clk), .rst(rst), .bus(bus16));
   ts_sync_lock_detector #(.PKT_LEN(PKT_LEN), .SYNC_BYTE(SYNC), .LOCK_CNT(LOCK_CNT),
                           .UNLOCK_CNT(UNLOCK_CNT), .CNT_W(4))
      dut4 (.clk(clk), .rst(rst), .bus(bus4));

   int n_tests = 0;
   int n_fail  = 0;
   int cyc     = 0;

   // Reference model: alignment is remembered as the valid-byte index of the anchoring sync byte.
   int         m_mode, m_vidx, m_anchor, m_hits, m_miss, m_pkt, m_err, m_loss;
   logic [7:0] m_data;
   bit         m_valid, m_start;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s (cycle %0d): got %0d, expected %0d", tag, cyc, got, exp);
      end
   endtask

   function automatic int sat(input int v, input int w);
      return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
   endfunction

   task automatic model_reset();
      m_mode = M_SEARCH; m_vidx = 0; m_anchor = 0; m_hits = 0; m_miss = 0;
      m_pkt = 0; m_err = 0; m_loss = 0; m_data = '0; m_valid = 0; m_start = 0;
   endtask

   task automatic model_step(input bit v, input logic [7:0] b);
      bit boundary;
      m_valid = 0;
      m_start = 0;
      if (!v) return;
      m_data   = b;
      boundary = ((m_vidx - m_anchor) % PKT_LEN) == 0;
      if (m_mode == M_SEARCH) begin
         if (b == SYNC) begin m_mode = M_VERIFY; m_anchor = m_vidx; m_hits = 1; end
      end else if (m_mode == M_VERIFY) begin
         if (boundary) begin
            if (b != SYNC) m_mode = M_SEARCH;
            else begin
               m_hits++;
               if (m_hits == LOCK_CNT) begin
                  m_mode = M_LOCKED; m_miss = 0; m_pkt++; m_valid = 1; m_start = 1;
               end
            end
         end
      end else begin
         m_valid = 1;
         m_start = boundary;
         if (boundary) begin
            if (b == SYNC) begin m_miss = 0; m_pkt++; end
            else begin
               m_err++; m_miss++;
               if (m_miss == UNLOCK_CNT) begin
                  m_mode = M_SEARCH; m_loss++; m_valid = 0; m_start = 0;
               end
            end
         end
      end
      m_vidx++;
   endtask

   task automatic check_all();
      check("lock16",     32'(bus16.lock),          32'(m_mode == M_LOCKED));
      check("valid16",    32'(bus16.valid_out),     32'(m_valid));
      check("start16",    32'(bus16.pkt_start),     32'(m_start));
      check("data16",     32'(bus16.data_out),      32'(m_data));
      check("pkt16",      32'(bus16.pkt_cnt),       32'(sat(m_pkt, 16)));
      check("err16",      32'(bus16.sync_err_cnt),  32'(sat(m_err, 16)));
      check("loss16",     32'(bus16.lock_loss_cnt), 32'(sat(m_loss, 16)));
      check("lock4",      32'(bus4.lock),           32'(m_mode == M_LOCKED));
      check("valid4",     32'(bus4.valid_out),      32'(m_valid));
      check("start4",     32'(bus4.pkt_start),      32'(m_start));
      check("pkt4",       32'(bus4.pkt_cnt),        32'(sat(m_pkt, 4)));
      check("err4",       32'(bus4.sync_err_cnt),   32'(sat(m_err, 4)));
      check("loss4",      32'(bus4.lock_loss_cnt),  32'(sat(m_loss, 4)));
   endtask

   task automatic cycle(input bit v, input logic [7:0] b);
      din = {v, 1'($urandom_range(0, 1)), b};
      model_step(v, b);
      @(posedge clk);
      #1;
      cyc++;
      check_all();
   endtask

   task automatic send_byte(input logic [7:0] b, input bit gaps);
      if (gaps && $urandom_range(0, 7) == 0)
         repeat ($urandom_range(1, 5)) cycle(1'b0, 8'($urandom));
      cycle(1'b1, b);
   endtask

   task automatic send_payload(input bit gaps);
      logic [7:0] b;
      for (int unsigned i = 1; i < PKT_LEN; i++) begin
         b = 8'($urandom);
         if (b == SYNC) b = 8'h46;
         send_byte(b, gaps);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      din = '0;
      model_reset();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
   endtask

   bit ever_locked;

   initial begin
      model_reset();
      do_reset();
      check("rst_lock", 32'(bus16.lock), 32'd0);
      check("rst_pkt",  32'(bus16.pkt_cnt), 32'd0);

      // Acquisition from three clean packets
      repeat (2) begin send_byte(SYNC, 0); send_payload(0); end
      check("t1_prelock", 32'(bus16.lock), 32'd0);
      send_byte(SYNC, 0);
      check("t1_lock",  32'(bus16.lock), 32'd1);
      check("t1_start", 32'(bus16.pkt_start), 32'd1);
      check("t1_valid", 32'(bus16.valid_out), 32'd1);
      check("t1_pkt",   32'(bus16.pkt_cnt), 32'd1);
      send_payload(0);

      // Single corrupted sync byte is flywheeled
      send_byte(8'h00, 0);
      check("t2_err",   32'(bus16.sync_err_cnt), 32'd1);
      check("t2_lock",  32'(bus16.lock), 32'd1);
      check("t2_start", 32'(bus16.pkt_start), 32'd1);
      send_payload(0);
      send_byte(SYNC, 0); send_payload(0);

      // Three consecutive misses drop lock, then relock
      repeat (2) begin send_byte(8'h00, 0); send_payload(0); end
      check("t3_hold", 32'(bus16.lock), 32'd1);
      send_byte(8'h00, 0);
      check("t3_unlock", 32'(bus16.lock), 32'd0);
      check("t3_valid",  32'(bus16.valid_out), 32'd0);
      check("t3_loss",   32'(bus16.lock_loss_cnt), 32'd1);
      send_payload(0);
      repeat (2) begin send_byte(SYNC, 0); send_payload(0); end
      send_byte(SYNC, 0);
      check("t3_relock", 32'(bus16.lock), 32'd1);
      send_payload(0);

      // Lone sync byte never repeated at its expected position
      do_reset();
      ever_locked = 0;
      for (int i = 0; i < 400; i++) begin
         logic [7:0] b;
         b = 8'($urandom);
         if (b == SYNC) b = 8'h00;
         if (i == 50) b = SYNC;
         cycle(1'b1, b);
         if (bus16.lock) ever_locked = 1;
      end
      check("t4_never_locked", 32'(ever_locked), 32'd0);
      check("t4_pkt", 32'(bus16.pkt_cnt), 32'd0);

      // Invalid gaps inside packets, then random corruption stress
      do_reset();
      repeat (2) begin send_byte(SYNC, 1); send_payload(1); end
      send_byte(SYNC, 1);
      check("t5_lock", 32'(bus16.lock), 32'd1);
      send_payload(1);
      repeat (14) begin
         send_byte(($urandom_range(0, 3) == 0) ? 8'(8'h40 + $urandom_range(0, 6)) : SYNC, 1);
         send_payload(1);
      end

      // Saturation with 20 good packets, then asynchronous reset mid-packet while locked
      do_reset();
      repeat (20) begin send_byte(SYNC, 0); send_payload(0); end
      check("t6_pkt16", 32'(bus16.pkt_cnt), 32'd18);
      check("t6_pkt4",  32'(bus4.pkt_cnt), 32'd15);
      send_byte(SYNC, 0);
      repeat (50) send_byte(8'h12, 0);
      check("t6_prelock", 32'(bus16.lock), 32'd1);
      #2 rst = 1'b1;
      model_reset();
      #1 check_all();
      @(posedge clk);
      #1;
      check_all();
      rst = 1'b0;
      repeat (3) begin send_byte(SYNC, 0); send_payload(0); end
      check("t6_relock", 32'(bus16.lock), 32'd1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
